// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types, register addresses and status bit layout.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic [31:0] TX_ADDR       = 32'h1001_0024;
    localparam logic [31:0] TX_DATA_ADDR  = 32'h1001_0028;
    localparam logic [31:0] RX_READY_ADDR = 32'h1001_002C;
    localparam logic [31:0] RX_DATA_ADDR  = 32'h1001_0030;
    localparam logic [31:0] CLEAN_RX_ADDR = 32'h1001_0034;

    localparam int READY_BIT = 0;
    localparam int FERR_BIT  = 1;
    localparam int OVR_BIT   = 2;

    localparam int DEFAULT_BAUD_DIV = 434;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Baud counter, held at zero while disabled; ticks after a full
//               or half bit period and restarts.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_half,
    output logic o_tick
);

    localparam int              C_W         = $clog2(BAUD_DIV);
    localparam logic [C_W-1:0]  C_FULL_LAST = C_W'(BAUD_DIV - 1);
    localparam logic [C_W-1:0]  C_HALF_LAST = C_W'(BAUD_DIV / 2 - 1);

    logic [C_W-1:0] cnt_q;
    logic [C_W-1:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        o_tick = 1'b0;
        if (!i_en) begin
            cnt_d = '0;
        end else if (cnt_q == (i_half ? C_HALF_LAST : C_FULL_LAST)) begin
            o_tick = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_regs.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_regs
// Description : 8N1 UART receiver with RX_READY / RX_DATA read words and a
//               CLEAN_RX write strobe that acknowledges the received byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_regs
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  Clean_rx_Memwrite,
    output logic [DATA_WIDTH-1:0] Rx_ReadData,
    output logic [DATA_WIDTH-1:0] Rx_ready_ReadData
);

    uart_state_e state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        ready_q, ready_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        w_tick;

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk    (clk),
        .rst    (reset),
        .i_en   (state_q != IDLE),
        .i_half (state_q == START),
        .o_tick (w_tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_byte_d = rx_byte_q;
        // An acknowledge is applied first so a coinciding stop-bit update wins.
        ready_d   = Clean_rx_Memwrite ? 1'b0 : ready_q;
        ferr_d    = Clean_rx_Memwrite ? 1'b0 : ferr_q;
        ovr_d     = Clean_rx_Memwrite ? 1'b0 : ovr_q;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (w_tick) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    state_d = IDLE;
                    if (rx_s_q) begin
                        rx_byte_d = shift_q;
                        ready_d   = 1'b1;
                        if (ready_q && !Clean_rx_Memwrite) begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            rx_byte_q <= 8'h00;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_byte_q <= rx_byte_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        Rx_ReadData            = '0;
        Rx_ReadData[7:0]       = rx_byte_q;
        Rx_ready_ReadData      = '0;
        Rx_ready_ReadData[READY_BIT] = ready_q;
        Rx_ready_ReadData[FERR_BIT]  = ferr_q;
        Rx_ready_ReadData[OVR_BIT]   = ovr_q;
    end

endmodule
`default_nettype wire
